oled_ctrl_sequencer: RTL and testbench
======================================

Name: oled_ctrl_sequencer

Overview:
Top-level OLED bring-up/shutdown controller. It sequences the SSD1331-class panel through its full life cycle:
- triggers the power-on pin sequencer and waits for it;
- streams a fixed init command list to the SPI byte master;
- enables VCC, turns the display on and reports ready;
- on disable, runs the ordered power-down.

It sits between the application enable and the power-on sequencer / SPI master pair.

Parameters:
- CLOCK_FREQUENCY_HZ, 200000000, sclk frequency. Microsecond tick every CLOCK_FREQUENCY_HZ/1000000 clocks.
- DEBUG, 0, when 1 every wait below becomes 10 us.
- VCC_WAIT_US, 25000, settle time after vcc_en rises, before display-on.
- DISP_ON_WAIT_US, 100000, wait after display-on command, before ready.
- VCC_OFF_WAIT_US, 400000, wait after vcc_en falls, before pmod_off.

Ports:
- sclk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  level; 1 = panel should be on
- pwr_start  out  1  one-cycle pulse to the power-on sequencer start
- pwr_done  in  1  one-cycle pulse from the power-on sequencer when finished
- cmd_data  out  8  command byte to the SPI master
- cmd_valid  out  1  cmd_data valid
- cmd_ready  in  1  SPI master accepts a byte
- vcc_en  out  1  panel VCC enable
- pmod_off  out  1  1 = force PMOD logic supply off
- ready  out  1  panel on and accepting pixel traffic
- busy  out  1  1 in every state except OFF and READY

Behaviour:
- Reset: state OFF. Reset values:
  - pwr_start=0, cmd_valid=0, cmd_data=0x00
  - vcc_en=0, pmod_off=1, ready=0, busy=0
  - timer cleared
- All outputs are registered. Reset applies in any state, including mid-transfer or mid-wait, and returns to OFF the next cycle.
- Timer: internal prescaler plus 32-bit microsecond counter. The counter is loaded on state entry. done asserts when the counter reaches the target in microseconds, i.e. after ≥ target µs and < target+1 µs.
- Init ROM, 16 bytes, index 0..15: FD 12 AE A0 72 A1 00 A2 00 A4 A8 3F AD 8E B0 0B.
- Handshake:
  - A byte transfers on any cycle with cmd_valid && cmd_ready.
  - cmd_data is stable while cmd_valid=1 and not yet accepted.
  - cmd_valid never drops before acceptance.
  - At most one byte is offered per 2 cycles; no back-to-back requirement.
- States and transitions:
  - OFF: pmod_off=1. On enable=1 → PWR_ON.
  - PWR_ON: pmod_off=0, pwr_start=1 for exactly one cycle → PWR_WAIT.
  - PWR_WAIT: on pwr_done → SEND, idx=0.
  - SEND: cmd_valid=1, cmd_data=ROM[idx]. On accept:
    - idx<15 → idx+1, stay in SEND;
    - idx=15 → VCC_ON, cmd_valid=0.
  - VCC_ON: vcc_en=1, start VCC_WAIT_US → VCC_WAIT.
  - VCC_WAIT: on timer done → DISP_ON.
  - DISP_ON: send 0xAF through the handshake. On accept → DISP_WAIT with DISP_ON_WAIT_US.
  - DISP_WAIT: on timer done → READY.
  - READY: ready=1. On enable=0 → OFF_CMD, with ready=0 from that transition.
  - OFF_CMD: send 0xAE. On accept → vcc_en=0, start VCC_OFF_WAIT_US → OFF_WAIT.
  - OFF_WAIT: on timer done → pmod_off=1 → OFF.
- enable=0 during bring-up:
  - The sequence completes through an in-flight byte, i.e. the current accept.
  - Then go to OFF_CMD if the power-on sequencer has finished, else wait for pwr_done first.
  - vcc_en=0 is reached in every case; ready never asserts.
- enable=1 during OFF_CMD/OFF_WAIT: ignored until OFF. A re-enable is then taken from OFF on the next cycle if enable is still 1.
- pwr_done outside PWR_WAIT: ignored.
- DEBUG=1: all three waits use 10 us.

Test Plan:
1. Bring-up. CLOCK_FREQUENCY_HZ=10000000, DEBUG=1, cmd_ready always 1, enable rises, pwr_done 5 cycles after pwr_start. Required:
   - one pwr_start pulse;
   - exactly 16 accepted bytes FD,12,…,0B in order;
   - vcc_en=1, then ≥100 cycles, then byte AF;
   - ready=1 ≥100 cycles later.
2. Backpressure. cmd_ready low for 7 cycles on every byte. Required: cmd_data is held stable, with no byte dropped or duplicated; the 16-byte sequence is identical to scenario 1.
3. Shutdown from READY, enable=0. Required:
   - ready=0 next cycle;
   - byte AE;
   - vcc_en=0 after the AE accept;
   - pmod_off=1 ≥100 cycles later; state OFF, busy=0.
4. enable=0 at ROM index 6 with cmd_ready stalled. Required: the byte at index 6 completes, then AE, vcc_en stays 0, pmod_off=1, and ready is never 1.
5. rst_n low for 1 cycle during VCC_WAIT. Required: next cycle vcc_en=0, pmod_off=1, cmd_valid=0, ready=0; a new enable restarts from pwr_start.
6. Spurious pwr_done in OFF and READY. Required: no state change or output change.

Source files
------------

// File: rtl/oled_ctrl_sequencer.sv
// oled_ctrl_sequencer: OLED panel power-up / init / shutdown sequencer.
// It drives the power-on pin sequencer, the init command stream to the SPI master, VCC and the PMOD supply.
module oled_ctrl_sequencer #(
    parameter int CLOCK_FREQUENCY_HZ = 200_000_000,
    parameter int DEBUG              = 0,
    parameter int VCC_WAIT_US        = 25_000,
    parameter int DISP_ON_WAIT_US    = 100_000,
    parameter int VCC_OFF_WAIT_US    = 400_000
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       pwr_start,
    input  logic       pwr_done,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       vcc_en,
    output logic       pmod_off,
    output logic       ready,
    output logic       busy
);
    localparam int          DIV    = CLOCK_FREQUENCY_HZ / 1_000_000;
    localparam logic [31:0] T_VCC  = DEBUG != 0 ? 32'd10 : 32'(VCC_WAIT_US);
    localparam logic [31:0] T_DISP = DEBUG != 0 ? 32'd10 : 32'(DISP_ON_WAIT_US);
    localparam logic [31:0] T_OFF  = DEBUG != 0 ? 32'd10 : 32'(VCC_OFF_WAIT_US);
    localparam logic [7:0]  ROM [16] = '{8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2,
                                         8'h00, 8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B};

    typedef enum logic [3:0] {
        OFF, PWR_ON, PWR_WAIT, SEND, VCC_ON, VCC_WAIT, DISP_ON, DISP_WAIT, READY, OFF_CMD, OFF_WAIT
    } state_t;

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [31:0] pre, us, target;
    logic [7:0]  byte_n;
    logic        done, accept, valid_n, vcc_n;

    assign accept = cmd_valid && cmd_ready;
    assign target = state == VCC_WAIT ? T_VCC : state == DISP_WAIT ? T_DISP : T_OFF;
    assign done   = us >= target;

    // An offered byte is never withdrawn: aborts only leave a byte state on accept or while nothing is offered.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        unique case (state)
            OFF:       if (enable) state_n = PWR_ON;
            PWR_ON:    state_n = PWR_WAIT;
            PWR_WAIT:  if (pwr_done) begin
                           state_n = enable ? SEND : OFF_CMD;
                           idx_n   = '0;
                       end
            SEND:      if (accept) begin
                           if (!enable) state_n = OFF_CMD;
                           else if (idx == 4'd15) state_n = VCC_ON;
                           else idx_n = idx + 4'd1;
                       end else if (!cmd_valid && !enable) state_n = OFF_CMD;
            VCC_ON:    state_n = enable ? VCC_WAIT : OFF_CMD;
            VCC_WAIT:  if (!enable) state_n = OFF_CMD; else if (done) state_n = DISP_ON;
            DISP_ON:   if (accept) state_n = enable ? DISP_WAIT : OFF_CMD;
                       else if (!cmd_valid && !enable) state_n = OFF_CMD;
            DISP_WAIT: if (!enable) state_n = OFF_CMD; else if (done) state_n = READY;
            READY:     if (!enable) state_n = OFF_CMD;
            OFF_CMD:   if (accept) state_n = OFF_WAIT;
            OFF_WAIT:  if (done) state_n = OFF;
            default:   state_n = OFF;
        endcase
        byte_n  = state_n == SEND ? ROM[idx_n] : state_n == DISP_ON ? 8'hAF : 8'hAE;
        valid_n = !accept && (state_n inside {SEND, DISP_ON, OFF_CMD});
        vcc_n   = state_n == OFF_CMD ? vcc_en : (state_n inside {VCC_ON, VCC_WAIT, DISP_ON, DISP_WAIT, READY});
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state     <= OFF;
            idx       <= '0;
            pre       <= '0;
            us        <= '0;
            pwr_start <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_data  <= 8'h00;
            vcc_en    <= 1'b0;
            pmod_off  <= 1'b1;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state_n != state) begin
                pre <= '0;
                us  <= '0;
            end else if (pre == 32'(DIV - 1)) begin
                pre <= '0;
                if (!done) us <= us + 32'd1;
            end else begin
                pre <= pre + 32'd1;
            end
            pwr_start <= state_n == PWR_ON;
            cmd_valid <= valid_n;
            if (valid_n) cmd_data <= byte_n;
            vcc_en    <= vcc_n;
            pmod_off  <= state_n == OFF;
            ready     <= state_n == READY;
            busy      <= !(state_n inside {OFF, READY});
        end
    end
endmodule

// File: tb/tb_oled_ctrl_sequencer.sv
// tb_oled_ctrl_sequencer: scoreboard bench; expected command bytes are queued by the stimulus
// and popped by an independent monitor on every accepted byte.
module tb_oled_ctrl_sequencer;
    logic       sclk = 1'b0, rst_n = 1'b0, enable = 1'b0, cmd_ready = 1'b0;
    logic       pwr_done_auto = 1'b0, pwr_done_spur = 1'b0;
    logic       pwr_done, pwr_start, cmd_valid, vcc_en, pmod_off, ready, busy;
    logic [7:0] cmd_data;

    assign pwr_done = pwr_done_auto | pwr_done_spur;

    oled_ctrl_sequencer #(.CLOCK_FREQUENCY_HZ(10_000_000), .DEBUG(1)) dut (
        .sclk(sclk), .rst_n(rst_n), .enable(enable), .pwr_start(pwr_start), .pwr_done(pwr_done),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .vcc_en(vcc_en),
        .pmod_off(pmod_off), .ready(ready), .busy(busy)
    );

    initial forever #5 sclk = ~sclk;

    logic [7:0] init_rom [16] = '{8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2,
                                  8'h00, 8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B};
    logic [7:0] exp_q [$];
    int checks = 0, errors = 0, cyc = 0;
    int ready_mode = 0, pwr_delay = 5, rdy_wait = 0, pd = 0;
    int n_acc = 0, n_pwr = 0;
    int vcc_rise = 0, vcc_fall = 0, pmod_rise = 0, ready_rise = 0, af_cyc = 0, ae_cyc = 0;
    bit ready_seen = 0, vcc_seen = 0, found = 0;
    logic pend = 0, prev_vcc = 0, prev_pmod = 1, prev_ready = 0;
    logic [7:0] pend_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
        #2;
    endtask

    function automatic logic sig(input int which);
        return which == 0 ? ready : which == 1 ? pmod_off : vcc_en;
    endfunction

    task automatic wait_for(input int which, input logic val, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (sig(which) == val) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s timeout after %0d cycles", name, budget);
    endtask

    initial forever @(posedge sclk) cyc++;

    // SPI master model: 0 = always ready, 1 = 7-cycle stall per byte, 2 = random
    initial forever begin
        @(negedge sclk);
        if (!cmd_valid) begin
            rdy_wait  = 0;
            cmd_ready = ready_mode == 0;
        end else begin
            cmd_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (rdy_wait >= 7) : ($urandom_range(0, 1) == 1);
            rdy_wait++;
        end
    end

    // power-on sequencer model
    initial forever begin
        @(negedge sclk);
        #1;
        if (pwr_start) begin
            pd = pwr_delay > 0 ? pwr_delay : int'($urandom_range(1, 8));
            repeat (pd) @(negedge sclk);
            pwr_done_auto = 1'b1;
            @(negedge sclk);
            pwr_done_auto = 1'b0;
        end
    end

    // monitor: scoreboard pop, hold-stability and event timestamps
    initial forever begin
        @(negedge sclk);
        #1;
        if (pwr_start) n_pwr++;
        if (ready) ready_seen = 1;
        if (vcc_en) vcc_seen = 1;
        if (vcc_en && !prev_vcc) vcc_rise = cyc;
        if (!vcc_en && prev_vcc) vcc_fall = cyc;
        if (pmod_off && !prev_pmod) pmod_rise = cyc;
        if (ready && !prev_ready) ready_rise = cyc;
        prev_vcc = vcc_en;
        prev_pmod = pmod_off;
        prev_ready = ready;
        if (pend && rst_n) begin
            check("hold_valid", cmd_valid, 1);
            check("hold_data", cmd_data, pend_data);
        end
        if (cmd_valid && cmd_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte_unexpected got %02h expected none", cmd_data);
            end else begin
                check("byte", cmd_data, exp_q.pop_front());
            end
            if (cmd_data == 8'hAF) af_cyc = cyc + 1;
            if (cmd_data == 8'hAE) ae_cyc = cyc + 1;
        end
        pend = cmd_valid && !cmd_ready;
        pend_data = cmd_data;
    end

    task automatic bring_up(input int mode);
        ready_mode = mode;
        n_acc = 0;
        n_pwr = 0;
        exp_q.delete();
        foreach (init_rom[i]) exp_q.push_back(init_rom[i]);
        exp_q.push_back(8'hAF);
        enable = 1'b1;
        wait_for(0, 1'b1, 4000, "ready_up");
        check("pwr_start_pulses", n_pwr, 1);
        check("bytes_accepted", n_acc, 17);
        check("queue_empty_up", exp_q.size(), 0);
        check("vcc_to_af_ge100", (af_cyc - vcc_rise) >= 100, 1);
        check("af_to_ready_ge100", (ready_rise - af_cyc) >= 100, 1);
        check("ready_busy", busy, 0);
        check("ready_pmod", pmod_off, 0);
        check("ready_vcc", vcc_en, 1);
    endtask

    task automatic shut_down();
        n_acc = 0;
        exp_q.push_back(8'hAE);
        enable = 1'b0;
        tick();
        check("ready_drop", ready, 0);
        wait_for(1, 1'b1, 3000, "pmod_off_down");
        tick();
        check("ae_accepted", n_acc, 1);
        check("queue_empty_down", exp_q.size(), 0);
        check("vcc_fall_at_ae", vcc_fall >= ae_cyc && vcc_fall <= ae_cyc + 1, 1);
        check("off_wait_ge100", (pmod_rise - vcc_fall) >= 100, 1);
        check("off_busy", busy, 0);
        check("off_vcc", vcc_en, 0);
        check("off_ready", ready, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_pwr_start", pwr_start, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_data", cmd_data, 8'h00);
        check("rst_vcc_en", vcc_en, 0);
        check("rst_pmod_off", pmod_off, 1);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        bring_up(0);
        shut_down();
        bring_up(1);
        shut_down();
        // abort while ROM byte 6 is stalled on the bus
        ready_mode = 1;
        n_acc = 0;
        ready_seen = 0;
        vcc_seen = 0;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(init_rom[i]);
        exp_q.push_back(8'hAE);
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (n_acc == 6 && cmd_valid && !cmd_ready) found = 1; else tick();
        end
        check("abort_point_found", found, 1);
        enable = 1'b0;
        wait_for(1, 1'b1, 3000, "abort_off");
        tick();
        check("abort_bytes", n_acc, 8);
        check("abort_queue_empty", exp_q.size(), 0);
        check("abort_ready_never", ready_seen, 0);
        check("abort_vcc_never", vcc_seen, 0);
        check("abort_busy", busy, 0);
        // reset during VCC_WAIT
        ready_mode = 2;
        pwr_delay = 0;
        n_acc = 0;
        exp_q.delete();
        foreach (init_rom[i]) exp_q.push_back(init_rom[i]);
        enable = 1'b1;
        wait_for(2, 1'b1, 3000, "vcc_up");
        repeat (20) tick();
        rst_n = 1'b0;
        enable = 1'b0;
        tick();
        check("mid_rst_vcc", vcc_en, 0);
        check("mid_rst_pmod", pmod_off, 1);
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bytes", n_acc, 16);
        rst_n = 1'b1;
        tick();
        bring_up(2);
        // spurious pwr_done in READY and OFF
        n_pwr = 0;
        pwr_done_spur = 1'b1;
        tick();
        pwr_done_spur = 1'b0;
        repeat (5) tick();
        check("spur_ready_ready", ready, 1);
        check("spur_ready_busy", busy, 0);
        check("spur_ready_vcc", vcc_en, 1);
        check("spur_ready_valid", cmd_valid, 0);
        check("spur_ready_pwr", n_pwr, 0);
        shut_down();
        n_pwr = 0;
        pwr_done_spur = 1'b1;
        tick();
        pwr_done_spur = 1'b0;
        repeat (5) tick();
        check("spur_off_pmod", pmod_off, 1);
        check("spur_off_busy", busy, 0);
        check("spur_off_valid", cmd_valid, 0);
        check("spur_off_pwr", n_pwr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
